// File: rtl/sound_sequencer.sv
// Sound effect sequencer: plays short fixed tunes (EAT, WIN, CRASH) as a
// sequence of note periods separated by silent gaps, timed by an external
// tick strobe. Higher-priority events preempt the tune being played.
// Optional feature: define SOUND_SEQ_QUEUE_EN to hold one unaccepted event
// and play it after the current tune completes.
module sound_sequencer #(
  parameter int NOTE_TICKS = 8,
  parameter int GAP_TICKS  = 2
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       en,
  input  logic       tick,
  input  logic       eat_evt,
  input  logic       win_evt,
  input  logic       crash_evt,
  output logic [7:0] freq,
  output logic       playSound,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  // Tune ids double as priority ranks; 0 means no tune.
  localparam logic [1:0] T_NONE  = 2'd0;
  localparam logic [1:0] T_EAT   = 2'd1;
  localparam logic [1:0] T_WIN   = 2'd2;
  localparam logic [1:0] T_CRASH = 2'd3;

  localparam logic [7:0] NOTE_LAST = 8'(NOTE_TICKS - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_TICKS - 1);

  state_t     state;
  logic [1:0] tune;
  logic [1:0] note_idx;
  logic [7:0] tick_cnt;
  logic [1:0] evt_pri;
  logic       accept;
  logic [1:0] start_tune;
`ifdef SOUND_SEQ_QUEUE_EN
  logic [1:0] pend;
`endif

  function automatic logic [7:0] note_of(input logic [1:0] t, input logic [1:0] k);
    logic [7:0] f;
    f = 8'd0;
    case (t)
      T_EAT:   f = (k == 2'd0) ? 8'd40 : 8'd30;
      T_WIN:   case (k)
                 2'd0:    f = 8'd60;
                 2'd1:    f = 8'd50;
                 2'd2:    f = 8'd40;
                 default: f = 8'd30;
               endcase
      T_CRASH: case (k)
                 2'd0:    f = 8'd100;
                 2'd1:    f = 8'd150;
                 default: f = 8'd200;
               endcase
      default: f = 8'd0;
    endcase
    return f;
  endfunction

  function automatic logic [1:0] last_of(input logic [1:0] t);
    logic [1:0] l;
    case (t)
      T_EAT:   l = 2'd1;
      T_WIN:   l = 2'd3;
      T_CRASH: l = 2'd2;
      default: l = 2'd0;
    endcase
    return l;
  endfunction

  // Pick the highest-ranked incoming event and decide whether it starts now.
  always_comb begin
    evt_pri = crash_evt ? T_CRASH : win_evt ? T_WIN : eat_evt ? T_EAT : T_NONE;
    accept  = en && (evt_pri != T_NONE) && ((state == IDLE) || (evt_pri > tune));
    start_tune = accept ? evt_pri : T_NONE;
`ifdef SOUND_SEQ_QUEUE_EN
    if (!accept && en && state == IDLE && pend != T_NONE) start_tune = pend;
`endif
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      tune      <= T_NONE;
      note_idx  <= 2'd0;
      tick_cnt  <= 8'd0;
      freq      <= 8'd0;
      playSound <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SOUND_SEQ_QUEUE_EN
      pend      <= T_NONE;
`endif
    end else begin
      done <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        tune      <= T_NONE;
        note_idx  <= 2'd0;
        tick_cnt  <= 8'd0;
        freq      <= 8'd0;
        playSound <= 1'b0;
        busy      <= 1'b0;
`ifdef SOUND_SEQ_QUEUE_EN
        pend      <= T_NONE;
`endif
      end else if (start_tune != T_NONE) begin
        // Start or preempt: note 0 of the new tune, tick on this cycle ignored.
        state     <= PLAY;
        tune      <= start_tune;
        note_idx  <= 2'd0;
        tick_cnt  <= 8'd0;
        freq      <= note_of(start_tune, 2'd0);
        playSound <= 1'b1;
        busy      <= 1'b1;
`ifdef SOUND_SEQ_QUEUE_EN
        if (!accept) pend <= T_NONE;
`endif
      end else begin
`ifdef SOUND_SEQ_QUEUE_EN
        // Remember the best event refused while a tune is playing.
        if (state != IDLE && evt_pri > pend) pend <= evt_pri;
`endif
        case (state)
          PLAY: if (tick) begin
            if (tick_cnt == NOTE_LAST) begin
              tick_cnt  <= 8'd0;
              playSound <= 1'b0;
              if (note_idx == last_of(tune)) begin
                state <= IDLE;
                tune  <= T_NONE;
                freq  <= 8'd0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= GAP;
              end
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
          GAP: if (tick) begin
            if (tick_cnt == GAP_LAST) begin
              state     <= PLAY;
              tick_cnt  <= 8'd0;
              note_idx  <= note_idx + 2'd1;
              freq      <= note_of(tune, note_idx + 2'd1);
              playSound <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: directed scenarios plus random traffic, all
// checked every cycle against a segment-based model of tune playback.
module tb_sound_sequencer;

  localparam int NT = 8;
  localparam int GT = 2;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       en = 1'b0, tick = 1'b0, eat_evt = 1'b0, win_evt = 1'b0, crash_evt = 1'b0;
  logic [7:0] freq;
  logic       playSound, busy, done;

  int checks = 0;
  int failures = 0;

  sound_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
    .clk(clk), .nRst(nRst), .en(en), .tick(tick),
    .eat_evt(eat_evt), .win_evt(win_evt), .crash_evt(crash_evt),
    .freq(freq), .playSound(playSound), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Model: a tune is a list of segments note0, gap, note1, gap, ... noteN.
  bit         m_active;
  int         m_cur, m_seg, m_tcnt;
  logic [7:0] m_freq;
  logic       m_play, m_busy, m_done;

  function automatic int tune_len(input int t);
    return (t == 1) ? 2 : (t == 2) ? 4 : (t == 3) ? 3 : 0;
  endfunction

  function automatic logic [7:0] tune_note(input int t, input int k);
    int eat_n[2]   = '{40, 30};
    int win_n[4]   = '{60, 50, 40, 30};
    int crash_n[3] = '{100, 150, 200};
    if (t == 1) return 8'(eat_n[k]);
    if (t == 2) return 8'(win_n[k]);
    if (t == 3) return 8'(crash_n[k]);
    return 8'd0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_cur = 0; m_seg = 0; m_tcnt = 0;
    m_freq = 8'd0; m_play = 1'b0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit t, input bit ea, input bit wi, input bit cr);
    int pr;
    pr = cr ? 3 : wi ? 2 : ea ? 1 : 0;
    m_done = 1'b0;
    if (!e) begin
      m_active = 0;
    end else if (pr != 0 && (!m_active || pr > m_cur)) begin
      m_active = 1; m_cur = pr; m_seg = 0; m_tcnt = 0;
    end else if (m_active && t) begin
      m_tcnt++;
      if (m_tcnt == ((m_seg % 2 == 0) ? NT : GT)) begin
        m_seg++; m_tcnt = 0;
        if (m_seg == 2 * tune_len(m_cur) - 1) begin
          m_active = 0; m_done = 1'b1;
        end
      end
    end
    if (m_active) begin
      m_freq = tune_note(m_cur, m_seg / 2);
      m_play = (m_seg % 2 == 0);
      m_busy = 1'b1;
    end else begin
      m_freq = 8'd0; m_play = 1'b0; m_busy = 1'b0;
    end
  endtask

  task automatic chk(input string tag);
    checks++;
    assert (freq === m_freq) else begin
      failures++; $error("FAIL %s freq got=%0d exp=%0d", tag, freq, m_freq);
    end
    checks++;
    assert (playSound === m_play) else begin
      failures++; $error("FAIL %s playSound got=%b exp=%b", tag, playSound, m_play);
    end
    checks++;
    assert (busy === m_busy) else begin
      failures++; $error("FAIL %s busy got=%b exp=%b", tag, busy, m_busy);
    end
    checks++;
    assert (done === m_done) else begin
      failures++; $error("FAIL %s done got=%b exp=%b", tag, done, m_done);
    end
  endtask

  // One clock: drive inputs, clock, update model, compare #1 after the edge.
  task automatic step(input string tag, input bit e, input bit t,
                      input bit ea, input bit wi, input bit cr);
    en = e; tick = t; eat_evt = ea; win_evt = wi; crash_evt = cr;
    @(posedge clk);
    #1;
    model_step(e, t, ea, wi, cr);
    chk(tag);
  endtask

  // Tick every 4th cycle until the model goes idle, within a cycle budget.
  task automatic run_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (m_active && n < budget) begin
      step(tag, 1, (n % 4) == 3, 0, 0, 0);
      n++;
    end
    checks++;
    assert (!m_active) else begin
      failures++; $error("FAIL %s timeout got=%0d exp=<%0d cycles", tag, n, budget);
    end
  endtask

  initial begin
    int n;
    model_reset();
    // Reset state
    #1;
    chk("reset");
    @(negedge clk);
    nRst = 1'b1;

    // First event right after reset; EAT with a tick every 4 cycles
    step("eat_start", 1, 0, 1, 0, 0);
    checks++;
    assert (freq === 8'd40) else begin
      failures++; $error("FAIL eat_first freq got=%0d exp=40", freq);
    end
    run_idle("eat_tune", 200);
    step("idle_after_eat", 1, 1, 0, 0, 0);

    // WIN preempted by CRASH during its 2nd note
    step("win_start", 1, 0, 0, 1, 0);
    n = 0;
    while (m_seg != 2 && n < 200) begin
      step("win_run", 1, (n % 3) == 2, 0, 0, 0);
      n++;
    end
    step("win_n2", 1, 0, 0, 0, 0);
    step("crash_preempt", 1, 1, 0, 0, 1);
    checks++;
    assert (freq === 8'd100 && playSound === 1'b1 && done === 1'b0) else begin
      failures++; $error("FAIL preempt freq/play/done got=%0d/%b/%b exp=100/1/0", freq, playSound, done);
    end
    step("win_during_crash", 1, 0, 0, 1, 0);
    run_idle("crash_tune", 300);

    // All three events at once; lower ones dropped
    step("all_evt", 1, 1, 1, 1, 1);
    step("eat_during_crash", 1, 0, 1, 0, 0);
    run_idle("crash_only", 300);
    repeat (3) step("idle_hold", 1, 1, 0, 0, 0);

    // en dropped mid-note, events ignored while low
    step("eat_en", 1, 0, 1, 0, 0);
    repeat (6) step("eat_en_run", 1, 1, 0, 0, 0);
    step("en_drop", 0, 0, 0, 0, 0);
    step("en_low_evt", 0, 1, 0, 0, 1);
    step("en_back", 1, 0, 0, 0, 0);

    // Reset asserted mid-gap, then a fresh EAT
    step("eat_gap", 1, 0, 1, 0, 0);
    n = 0;
    while (m_seg != 1 && n < 50) begin
      step("to_gap", 1, 1, 0, 0, 0);
      n++;
    end
    #2 nRst = 1'b0;
    #1;
    model_reset();
    chk("reset_mid_gap");
    @(negedge clk);
    nRst = 1'b1;
    step("eat_after_rst", 1, 0, 1, 0, 0);
    run_idle("eat_after_rst_tune", 200);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      step("rand", ($urandom % 80) != 0, ($urandom % 3) == 0,
           ($urandom % 40) == 0, ($urandom % 70) == 0, ($urandom % 110) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
